load_store_unit: RTL and testbench

Parametrised load/store unit placed between the multi-cycle core datapath and the unified memory/MMIO block. It replaces the current whole-word memory path, with its separate result extender and register truncater, by one sequential unit. The unit accepts one load or store per request handshake, checks alignment and `funct3` legality, and drives a word-addressed bus with byte enables. It tolerates a variable number of wait states, enforces a bus timeout, and returns a sign- or zero-extended result through a response handshake.

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bundles the core-side request/response handshakes and the word-addressed memory bus
// of the load/store unit.
interface load_store_unit_if #(
   parameter int XLEN       = 32,
   parameter int MEM_ADDR_W = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [2:0]            req_funct3;
   logic [31:0]           req_addr;
   logic [XLEN-1:0]       req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [XLEN-1:0]       rsp_rdata;
   logic [1:0]            rsp_err;
   logic                  mem_req;
   logic                  mem_we;
   logic [XLEN/8-1:0]     mem_be;
   logic [MEM_ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]       mem_wdata;
   logic                  mem_ack;
   logic [XLEN-1:0]       mem_rdata;

   // The environment (core plus memory) drives requests and bus completions.
   modport master (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
             mem_ack, mem_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, rsp_ready,
             mem_ack, mem_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Sequential load/store unit: checks funct3/alignment, drives a byte-enabled word bus with
// wait-state tolerance and timeout, and returns an extended load result.
module load_store_unit #(
   parameter int XLEN       = 32,
   parameter int MEM_ADDR_W = 16,
   parameter int MAX_WAIT   = 255
) (
   input logic               clk,
   input logic               rst,
   load_store_unit_if.slave  bus
);
   localparam int NB     = XLEN / 8;
   localparam int OFF_W  = $clog2(NB);
   localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                r_state, w_next;
   logic                  r_write;
   logic [2:0]            r_funct3;
   logic [31:0]           r_addr;
   logic [XLEN-1:0]       r_wdata;
   logic [WAIT_W-1:0]     r_wait;
   logic [XLEN-1:0]       r_rdata;
   logic [1:0]            r_err;

   logic                  w_accept, w_illegal, w_misalign, w_timeout;
   logic [OFF_W-1:0]      w_off;
   logic [NB-1:0]         w_size_mask;
   logic [XLEN-1:0]       w_lane;

   function automatic logic f_legal(input logic wr, input logic [2:0] f3);
      logic ok;
      if (wr) ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   ((XLEN == 64) && (f3 == 3'b011));
      else    ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                   (f3 == 3'b100) || (f3 == 3'b101) ||
                   ((XLEN == 64) && ((f3 == 3'b011) || (f3 == 3'b110)));
      return ok;
   endfunction

   function automatic logic f_misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] off);
      logic [OFF_W-1:0] mask;
      mask = OFF_W'((32'd1 << f3[1:0]) - 32'd1);
      return |(off & mask);
   endfunction

   // Sign/zero extension by shifting the field to the top and back down.
   function automatic logic [XLEN-1:0] f_extend(input logic [2:0] f3, input logic [XLEN-1:0] lane);
      int unsigned            sh;
      logic signed [XLEN-1:0] s;
      case (f3[1:0])
         2'b00:   sh = XLEN - 8;
         2'b01:   sh = XLEN - 16;
         2'b10:   sh = XLEN - 32;
         default: sh = 0;
      endcase
      s = $signed(lane << sh);
      if (f3[2]) return (lane << sh) >> sh;
      else       return $unsigned(s >>> sh);
   endfunction

   assign w_accept    = (r_state == S_IDLE) && bus.req_valid;
   assign w_illegal   = !f_legal(bus.req_write, bus.req_funct3);
   assign w_misalign  = f_misaligned(bus.req_funct3, bus.req_addr[OFF_W-1:0]);
   assign w_timeout   = (r_wait == WAIT_W'(MAX_WAIT - 1));
   assign w_off       = r_addr[OFF_W-1:0];
   assign w_size_mask = NB'((32'd1 << (32'd1 << r_funct3[1:0])) - 32'd1);
   assign w_lane      = bus.mem_rdata >> {w_off, 3'b000};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      bus.req_ready  = (r_state == S_IDLE);
      bus.rsp_valid  = (r_state == S_RESP);
      bus.rsp_rdata  = r_rdata;
      bus.rsp_err    = r_err;
      bus.mem_req    = 1'b0;
      bus.mem_we     = 1'b0;
      bus.mem_be     = '0;
      bus.mem_addr   = '0;
      bus.mem_wdata  = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.req_valid) w_next = (w_illegal || w_misalign) ? S_RESP : S_ACCESS;
         end
         S_ACCESS: begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = r_write;
            bus.mem_be    = w_size_mask << w_off;
            bus.mem_addr  = r_addr[MEM_ADDR_W+OFF_W-1:OFF_W];
            bus.mem_wdata = r_wdata << {w_off, 3'b000};
            if (bus.mem_ack || w_timeout) w_next = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_write  <= bus.req_write;
         r_funct3 <= bus.req_funct3;
         r_addr   <= bus.req_addr;
         r_wdata  <= bus.req_wdata;
      end
   end

   // Illegal funct3 outranks misalignment when both apply.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wait  <= '0;
         r_rdata <= '0;
         r_err   <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid) begin
                  r_wait  <= '0;
                  r_rdata <= '0;
                  r_err   <= w_illegal ? 2'b10 : (w_misalign ? 2'b01 : 2'b00);
               end
            end
            S_ACCESS: begin
               if (bus.mem_ack) begin
                  r_err   <= 2'b00;
                  r_rdata <= r_write ? '0 : f_extend(r_funct3, w_lane);
               end else if (w_timeout) begin
                  r_err   <= 2'b11;
                  r_rdata <= '0;
               end else begin
                  r_wait  <= r_wait + WAIT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (XLEN=32, MAX_WAIT=4) with hand-computed expectations.
module tb_load_store_unit;
   localparam int XLEN = 32;
   localparam int MAW  = 16;
   localparam int MW   = 4;

   logic clk;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   load_store_unit_if #(.XLEN(XLEN), .MEM_ADDR_W(MAW)) bus();

   load_store_unit #(.XLEN(XLEN), .MEM_ADDR_W(MAW), .MAX_WAIT(MW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called #1 after a rising edge with the unit idle; ack_at = ACCESS cycle (1-based) to ack, 0 = never.
   task automatic txn(input string tag, input bit w, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                      input logic [1:0] eerr, input logic [31:0] erd, input logic [3:0] ebe,
                      input logic [15:0] eaddr, input logic [31:0] ewd, input bit hold);
      int n;
      int ecyc;
      bus.rsp_ready  = !hold;
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      chk({tag, "_req_ready"}, bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      n = 0;
      while (bus.mem_req && n < 50) begin
         n++;
         if (n == 1) begin
            chk({tag, "_mem_we"},    bus.mem_we, w);
            chk({tag, "_mem_be"},    bus.mem_be, ebe);
            chk({tag, "_mem_addr"},  bus.mem_addr, eaddr);
            chk({tag, "_mem_wdata"}, bus.mem_wdata, ewd);
         end
         if (n == ack_at) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd;
         end
         @(posedge clk); #1;
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = '0;
      end
      if (eerr == 2'b01 || eerr == 2'b10) ecyc = 0;
      else if (ack_at > 0)                ecyc = ack_at;
      else                                ecyc = MW;
      chk({tag, "_bus_cycles"}, n, ecyc);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 1);
      chk({tag, "_rsp_err"},   bus.rsp_err, eerr);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, erd);
      if (hold) begin
         repeat (5) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h0BAD_0BAD;
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, bus.rsp_valid, 1);
            chk({tag, "_hold_rdata"}, bus.rsp_rdata, erd);
            chk({tag, "_hold_ready"}, bus.req_ready, 0);
         end
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = '0;
         bus.rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      chk({tag, "_idle_valid"}, bus.rsp_valid, 0);
      chk({tag, "_idle_ready"}, bus.req_ready, 1);
   endtask

   initial begin
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b1;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = '0;
      #1 rst = 1'b0;
      #1;
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_rsp_err",   bus.rsp_err, 0);
      chk("rst_mem_req",   bus.mem_req, 0);
      chk("rst_mem_we",    bus.mem_we, 0);
      chk("rst_mem_be",    bus.mem_be, 0);
      chk("rst_mem_addr",  bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      //  tag     w  f3      addr          wdata         ack rdata         err    erdata         be       maddr   mwdata        hold
      txn("sb",   1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'h0,         2'b00, 32'h0,         4'b1000, 16'h40, 32'hA500_0000, 0);
      txn("lb",   0, 3'b000, 32'h0000_0102, 32'h0,         1, 32'h12F0_4567, 2'b00, 32'hFFFF_FFF0, 4'b0100, 16'h40, 32'h0,         0);
      txn("lbu",  0, 3'b100, 32'h0000_0102, 32'h0,         1, 32'h12F0_4567, 2'b00, 32'h0000_00F0, 4'b0100, 16'h40, 32'h0,         0);
      txn("lh",   0, 3'b001, 32'h0000_0102, 32'h0,         1, 32'h12F0_4567, 2'b00, 32'h0000_12F0, 4'b1100, 16'h40, 32'h0,         0);
      txn("lb3",  0, 3'b000, 32'h0000_0103, 32'h0,         1, 32'h12F0_4567, 2'b00, 32'h0000_0012, 4'b1000, 16'h40, 32'h0,         0);
      txn("lb1",  0, 3'b000, 32'h0000_0001, 32'h0,         1, 32'h0000_8000, 2'b00, 32'hFFFF_FF80, 4'b0010, 16'h00, 32'h0,         0);
      txn("lhu",  0, 3'b101, 32'h0000_0002, 32'h0,         1, 32'h8001_0000, 2'b00, 32'h0000_8001, 4'b1100, 16'h00, 32'h0,         0);
      txn("lhs",  0, 3'b001, 32'h0000_0002, 32'h0,         1, 32'h8001_0000, 2'b00, 32'hFFFF_8001, 4'b1100, 16'h00, 32'h0,         0);
      txn("sh",   1, 3'b001, 32'h0000_0006, 32'h1234_ABCD, 1, 32'h0,         2'b00, 32'h0,         4'b1100, 16'h01, 32'hABCD_0000, 0);
      txn("sw",   1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 1, 32'h0,         2'b00, 32'h0,         4'b1111, 16'h02, 32'hCAFE_F00D, 0);
      txn("lwmis",0, 3'b010, 32'h0000_0202, 32'h0,         1, 32'h0,         2'b01, 32'h0,         4'b0000, 16'h00, 32'h0,         0);
      txn("lhmis",0, 3'b001, 32'h0000_0101, 32'h0,         1, 32'h0,         2'b01, 32'h0,         4'b0000, 16'h00, 32'h0,         0);
      txn("ld32", 0, 3'b011, 32'h0000_0200, 32'h0,         1, 32'h0,         2'b10, 32'h0,         4'b0000, 16'h00, 32'h0,         0);
      txn("prio", 0, 3'b111, 32'h0000_0201, 32'h0,         1, 32'h0,         2'b10, 32'h0,         4'b0000, 16'h00, 32'h0,         0);
      txn("sbad", 1, 3'b100, 32'h0000_0000, 32'h0,         1, 32'h0,         2'b10, 32'h0,         4'b0000, 16'h00, 32'h0,         0);
      txn("tmo",  0, 3'b010, 32'h0000_0010, 32'h0,         0, 32'hFFFF_FFFF, 2'b11, 32'h0,         4'b1111, 16'h04, 32'h0,         0);
      txn("ack3", 0, 3'b010, 32'h0000_0010, 32'h0,         3, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF, 4'b1111, 16'h04, 32'h0,         0);
      txn("hold", 0, 3'b010, 32'h0000_0024, 32'h0,         1, 32'h0000_55AA, 2'b00, 32'h0000_55AA, 4'b1111, 16'h09, 32'h0,         1);

      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h0000_0030;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("arst_pre_mem_req", bus.mem_req, 1);
      #3 rst = 1'b0;
      #1;
      chk("arst_mem_req",   bus.mem_req, 0);
      chk("arst_rsp_valid", bus.rsp_valid, 0);
      chk("arst_req_ready", bus.req_ready, 1);
      @(posedge clk); #1;
      chk("arst_hold_valid", bus.rsp_valid, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      txn("post", 0, 3'b010, 32'h0000_0030, 32'h0, 2, 32'h1122_3344, 2'b00, 32'h1122_3344, 4'b1111, 16'h0C, 32'h0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
